// File: rtl/tile_rect_drawer.sv
// tile_rect_drawer: row-major rectangle fill, one clipped pixel write
// per clock toward the VGA adapter; one command via valid/ready.
//
// Ports:
//   clock, reset (async, active-low)
//   cmd_valid/cmd_ready : command handshake, ready only in IDLE
//   cmd_x0, cmd_y0      : top-left corner
//   cmd_w, cmd_h        : size in pixels, 0 means empty
//   cmd_colour          : fill colour
//   vga_x/y/colour/write: registered pixel write
//   busy                : DRAW or DONE
//   done                : one-cycle completion pulse
module tile_rect_drawer #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_colour,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_write,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [X_W:0] LP_SW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LP_SH = (Y_W+1)'(SCREEN_H);

  state_t             r_state;
  logic [X_W-1:0]     r_x0;
  logic [Y_W-1:0]     r_y0;
  logic [X_W-1:0]     r_w;
  logic [Y_W-1:0]     r_h;
  logic [X_W-1:0]     r_cx;
  logic [Y_W-1:0]     r_cy;
  logic [X_W-1:0]     r_vga_x;
  logic [Y_W-1:0]     r_vga_y;
  logic [COLOR_W-1:0] r_vga_colour;
  logic               r_vga_write;
  logic               r_done;

  logic               w_cx_end;
  logic               w_cy_end;
  logic               w_last;
  logic [X_W-1:0]     w_ncx;
  logic [Y_W-1:0]     w_ncy;
  logic [X_W:0]       w_xs;
  logic [Y_W:0]       w_ys;
  logic [X_W:0]       w_axs;
  logic [Y_W:0]       w_ays;
  logic               w_empty;

  // cx never exceeds w-1, so equality is the end-of-row test.
  assign w_cx_end = (r_cx == r_w - 1'b1);
  assign w_cy_end = (r_cy == r_h - 1'b1);
  assign w_last   = w_cx_end && w_cy_end;
  assign w_ncx    = w_cx_end ? '0 : r_cx + 1'b1;
  assign w_ncy    = w_cx_end ? r_cy + 1'b1 : r_cy;

  // One extra bit so sums past the coordinate range clip, not wrap.
  assign w_xs  = {1'b0, r_x0} + {1'b0, w_ncx};
  assign w_ys  = {1'b0, r_y0} + {1'b0, w_ncy};
  assign w_axs = {1'b0, cmd_x0};
  assign w_ays = {1'b0, cmd_y0};

  assign w_empty = (cmd_w == '0) || (cmd_h == '0);

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = !cmd_ready;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_write  = r_vga_write;
  assign done       = r_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_write  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done      <= 1'b0;
          r_vga_write <= 1'b0;
          if (cmd_valid) begin
            r_x0 <= cmd_x0;
            r_y0 <= cmd_y0;
            r_w  <= cmd_w;
            r_h  <= cmd_h;
            r_cx <= '0;
            r_cy <= '0;
            if (w_empty) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              // Pixel 0 is presented straight from the command.
              r_state      <= S_DRAW;
              r_vga_x      <= w_axs[X_W-1:0];
              r_vga_y      <= w_ays[Y_W-1:0];
              r_vga_colour <= cmd_colour;
              r_vga_write  <= (w_axs < LP_SW) &&
                              (w_ays < LP_SH);
            end
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_state     <= S_DONE;
            r_vga_write <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_cx        <= w_ncx;
            r_cy        <= w_ncy;
            r_vga_x     <= w_xs[X_W-1:0];
            r_vga_y     <= w_ys[Y_W-1:0];
            r_vga_write <= (w_xs < LP_SW) &&
                           (w_ys < LP_SH);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_rect_drawer.sv
// tb_tile_rect_drawer: directed checks of tile_rect_drawer
// against hand-computed pixel sequences and handshake timing.
module tb_tile_rect_drawer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_x0;
  logic [8:0] cmd_y0;
  logic [9:0] cmd_w;
  logic [8:0] cmd_h;
  logic [2:0] cmd_colour;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;
  logic       busy;
  logic       done;

  int n_chk;
  int n_err;

  tile_rect_drawer dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: sim still running, limit 2ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int x0, input int y0,
                         input int w, input int h,
                         input int c);
    cmd_x0     = 10'(x0);
    cmd_y0     = 9'(y0);
    cmd_w      = 10'(w);
    cmd_h      = 9'(h);
    cmd_colour = 3'(c);
  endtask

  // Leaves the bench in cycle E0+1 with inputs scrambled.
  task automatic send(input int x0, input int y0,
                      input int w, input int h,
                      input int c);
    chk("ready_before_send", cmd_ready, 1);
    set_cmd(x0, y0, w, h, c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    set_cmd(1, 1, 9, 9, 7);
  endtask

  task automatic chk_pix(input string tag, input int x,
                         input int y, input int c,
                         input int wr);
    chk({tag, "_wr"}, vga_write, wr);
    chk({tag, "_x"}, vga_x, x);
    chk({tag, "_y"}, vga_y, y);
    if (wr != 0) chk({tag, "_col"}, vga_colour, c);
  endtask

  int bx[6] = '{10, 11, 12, 10, 11, 12};
  int by[6] = '{20, 20, 20, 21, 21, 21};
  int cx[8] = '{638, 639, 640, 641, 638, 639, 640, 641};
  int cy[8] = '{479, 479, 479, 479, 480, 480, 480, 480};
  int cw[8] = '{1, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0, 0);

    // Reset held while cmd_valid toggles.
    set_cmd(5, 5, 2, 2, 3);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = (i % 2 == 0);
      step();
      chk("rst_x", vga_x, 0);
      chk("rst_y", vga_y, 0);
      chk("rst_col", vga_colour, 0);
      chk("rst_wr", vga_write, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 1);
    end
    cmd_valid = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wr", vga_write, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end

    // Basic 3x2 fill.
    send(10, 20, 3, 2, 5);
    for (int k = 0; k < 6; k++) begin
      chk_pix("basic", bx[k], by[k], 5, 1);
      chk("basic_busy", busy, 1);
      chk("basic_done_lo", done, 0);
      step();
    end
    chk("basic_done", done, 1);
    chk("basic_done_wr", vga_write, 0);
    chk("basic_done_ready", cmd_ready, 0);
    step();
    chk("basic_ready", cmd_ready, 1);
    chk("basic_done_clr", done, 0);

    // Empty command.
    send(30, 40, 0, 5, 2);
    chk("empty_done", done, 1);
    chk("empty_wr", vga_write, 0);
    chk("empty_busy", busy, 1);
    step();
    chk("empty_ready", cmd_ready, 1);
    chk("empty_done_clr", done, 0);
    chk("empty_wr2", vga_write, 0);

    // Clip at the bottom-right corner.
    send(638, 479, 4, 2, 6);
    for (int k = 0; k < 8; k++) begin
      chk_pix("clip", cx[k], cy[k], 6, cw[k]);
      step();
    end
    chk("clip_done", done, 1);
    step();
    chk("clip_ready", cmd_ready, 1);

    // x sum past 10 bits: low bits wrap, write stays off.
    send(1023, 0, 2, 1, 1);
    chk_pix("wrap0", 1023, 0, 1, 0);
    step();
    chk_pix("wrap1", 0, 0, 1, 0);
    step();
    chk("wrap_done", done, 1);
    step();

    // Busy ignore, then back-to-back accept.
    send(100, 50, 2, 2, 2);
    set_cmd(0, 0, 1, 1, 7);
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_pix("busy", 100 + k % 2, 50 + k / 2, 2, 1);
      chk("busy_ready", cmd_ready, 0);
      if (k == 2) cmd_valid = 1'b0;
      step();
    end
    chk("busy_done", done, 1);
    chk("busy_done_wr", vga_write, 0);
    set_cmd(5, 6, 1, 1, 4);
    cmd_valid = 1'b1;
    step();
    chk("b2b_ready", cmd_ready, 1);
    chk("b2b_wr_idle", vga_write, 0);
    step();
    cmd_valid = 1'b0;
    chk_pix("b2b", 5, 6, 4, 1);
    step();
    chk("b2b_done", done, 1);
    step();
    chk("b2b_ready2", cmd_ready, 1);

    // Reset in the middle of an 8x1 rectangle.
    send(200, 100, 8, 1, 1);
    for (int k = 0; k < 3; k++) begin
      chk_pix("mid", 200 + k, 100, 1, 1);
      if (k < 2) step();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_wr", vga_write, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_hold_done", done, 0);
      chk("mid_hold_wr", vga_write, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_rel_done", done, 0);
      chk("mid_rel_wr", vga_write, 0);
      chk("mid_rel_ready", cmd_ready, 1);
    end
    send(300, 200, 1, 1, 6);
    chk_pix("after", 300, 200, 6, 1);
    step();
    chk("after_done", done, 1);
    chk("after_wr", vga_write, 0);
    step();
    chk("after_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
